jtag_debug_host_scan_driver: RTL and testbench
==============================================

// Module: jtag_debug_host_scan_driver
// PURPOSE
//  Host-side (initiator) end of the Nios II JTAG debug-module virtual-JTAG interface.
//  Accepts IR/DR scan commands from a local sequencer and generates the virtual-JTAG signals that feed the debug module's tck domain:
//   - tck, tdi, ir_in and the uir/cdr/sdr/udr/rti states.
//  Captures tdo into a response.
//  Replaces sld_virtual_jtag_basic for on-chip self-debug and simulation of the debug module.
// PARAMETERS
//  DR_WIDTH  38  data-register scan length in bits (matches jdo/sr width)
//  IR_WIDTH  2   virtual IR width
//  TCK_HALF  2   clk cycles per tck half-period (>=1)
// PORTS
//  clk         in   1         system clock
//  reset_n     in   1         async active-low reset
//  cmd_valid   in   1         scan command valid
//  cmd_ready   out  1         command accepted when valid&&ready
//  cmd_ir      in   IR_WIDTH  IR value for this scan
//  cmd_dr      in   DR_WIDTH  DR data shifted in, LSB first
//  rsp_valid   out  1         captured DR available
//  rsp_ready   in   1         response consumed when valid&&ready
//  rsp_dr      out  DR_WIDTH  bits captured from tdo, LSB first
//  busy        out  1         high in any state except IDLE
//  tck         out  1         generated test clock
//  tdi         out  1         serial data to target
//  tdo         in   1         serial data from target
//  ir_in       out  IR_WIDTH  virtual IR to target
//  vs_uir      out  1         update-IR state
//  vs_cdr      out  1         capture-DR state
//  vs_sdr      out  1         shift-DR state
//  vs_udr      out  1         update-DR state
//  jtag_state_rti  out  1     run-test-idle state
// BEHAVIOUR
//  Reset: all outputs 0, including tck, ir_in, rsp_dr, cmd_ready and state flags.
//   - State IDLE; first cycle after reset release cmd_ready=1.
//  States: IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> RESP -> IDLE.
//   - Exactly one state flag is high, matching the state; none in IDLE/RESP.
//  Accept: in IDLE, cmd_ready=1. On valid&&ready, latch cmd_ir into ir_in and cmd_dr into shreg; enter UIR the next cycle.
//  cmd_ready=0 in all other states; commands are never queued.
//  tck: 0 in IDLE/RESP. In scan states a half-period counter (0..TCK_HALF-1) toggles tck at terminal count.
//   - "rise": toggle 0->1. "fall": toggle 1->0.
//   - Each state entry starts with tck=0 and a fresh counter.
//  State advance only on fall. UIR, CDR, UDR, RTI: one tck period each. SDR: DR_WIDTH periods, counted by a bit counter.
//  tdi = shreg[0] in SDR, else 0. Changes only at fall/entry (stable across rise).
//  On each SDR rise: shreg <= {tdo, shreg[DR_WIDTH-1:1]}.
//  Leaving RTI: rsp_dr <= shreg, rsp_valid=1 (state RESP).
//  rsp_valid and rsp_dr are held stable until rsp_ready. Then next cycle: IDLE, rsp_valid=0, cmd_ready=1.
//  ir_in holds its value past RESP until the next accept. rsp_dr holds until the next response.
//  Latency: accept at cycle T -> rsp_valid at T+1+(4+DR_WIDTH)*2*TCK_HALF (defaults: T+169).
//  Async reset mid-scan: immediate return to IDLE/reset values. The partial scan is dropped and no response is issued.
//  cmd_valid while busy is ignored; the source must hold it.
// STRUCTURE
//  Package jtag_host_pkg:
//   - state enum
//   - DR_WIDTH/IR_WIDTH defaults
//   - localparam bit-counter width $clog2(DR_WIDTH+1)
//  Sub-module jtag_tck_gen:
//   - half-period counter, tck register, rise/fall pulses
//   - enable and sync-restart inputs
//  Parent holds FSM, shreg, bit counter and response registers.
// TESTING
//  1. Reset, hold 5 cycles -> all outputs 0; after release cmd_ready=1, tck=0.
//  2. ir=2'b01, dr=38'h2A_5555_5555; target model preloaded 38'h3F_0000_1234 shifting on tck:
//     - target receives 38'h2A_5555_5555 and sees ir_in=01 at uir
//     - rsp_dr=38'h3F_0000_1234 at T+169.
//  3. cmd_valid held high with a second command -> cmd_ready=0 until first response is consumed. Second scan starts the cycle after IDLE accept.
//  4. rsp_ready low 10 cycles after rsp_valid -> rsp_valid/rsp_dr stable; tck stays 0; no accept.
//  5. Assert reset_n=0 at SDR bit 17 -> same cycle tck=0, vs_sdr=0; after release IDLE and no rsp_valid.
//  6. TCK_HALF=1, ir=2'b10, dr=0 with tdo tied 1 -> rsp_dr=38'h3F_FFFF_FFFF at T+85; tck period is 2 clk.

Source files
------------

// File: rtl/jtag_host_pkg.sv
// Shared types and defaults for the host-side virtual-JTAG scan driver.
package jtag_host_pkg;

  localparam int DR_WIDTH_DEFAULT = 38;
  localparam int IR_WIDTH_DEFAULT = 2;
  localparam int BIT_CNT_W        = $clog2(DR_WIDTH_DEFAULT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } state_t;

endpackage

// File: rtl/jtag_tck_gen.sv
// Test-clock generator: divides clk into a tck of 2*TCK_HALF clk cycles and
// flags the cycle on which tck is about to rise or fall.
module jtag_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam logic [CW-1:0] TERM = CW'(TCK_HALF - 1);

  logic [CW-1:0] cnt;
  logic          term;

  // rise/fall are asserted on the clk cycle whose closing edge toggles tck
  assign term = enable && (cnt == TERM);
  assign rise = term && !tck;
  assign fall = term && tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!enable || restart) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (cnt == TERM) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_debug_host_scan_driver.sv
// Initiator end of the debug-module virtual-JTAG link: runs one IR/DR scan per
// accepted command and returns the bits captured from tdo.
module jtag_debug_host_scan_driver
  import jtag_host_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
  parameter int IR_WIDTH = IR_WIDTH_DEFAULT,
  parameter int TCK_HALF = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                busy,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int BCW = $clog2(DR_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DR_WIDTH - 1);

  state_t              state;
  state_t              next_state;
  logic [DR_WIDTH-1:0] shreg;
  logic [BCW-1:0]      bit_cnt;
  logic                armed;
  logic                accept;
  logic                scan_en;
  logic                rise;
  logic                fall;

  // armed keeps cmd_ready low while reset is held and for the release cycle
  assign cmd_ready = armed && (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign scan_en   = (state != ST_IDLE) && (state != ST_RESP);

  jtag_tck_gen #(
    .TCK_HALF(TCK_HALF)
  ) u_tck_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (scan_en),
    .restart(accept),
    .tck    (tck),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    vs_uir         = 1'b0;
    vs_cdr         = 1'b0;
    vs_sdr         = 1'b0;
    vs_udr         = 1'b0;
    jtag_state_rti = 1'b0;
    case (state)
      ST_IDLE: if (accept) next_state = ST_UIR;
      ST_UIR: begin
        vs_uir = 1'b1;
        if (fall) next_state = ST_CDR;
      end
      ST_CDR: begin
        vs_cdr = 1'b1;
        if (fall) next_state = ST_SDR;
      end
      ST_SDR: begin
        vs_sdr = 1'b1;
        if (fall && (bit_cnt == LAST_BIT)) next_state = ST_UDR;
      end
      ST_UDR: begin
        vs_udr = 1'b1;
        if (fall) next_state = ST_RTI;
      end
      ST_RTI: begin
        jtag_state_rti = 1'b1;
        if (fall) next_state = ST_RESP;
      end
      ST_RESP: if (rsp_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // tdi is registered at fall so it never moves while the target samples on rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed   <= 1'b0;
      ir_in   <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      tdi     <= 1'b0;
      rsp_dr  <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        ir_in   <= cmd_ir;
        shreg   <= cmd_dr;
        bit_cnt <= '0;
      end
      if ((state == ST_SDR) && rise) begin
        shreg <= {tdo, shreg[DR_WIDTH-1:1]};
      end
      if ((state == ST_SDR) && fall) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall) begin
        tdi <= (next_state == ST_SDR) ? shreg[0] : 1'b0;
      end
      if ((state == ST_RTI) && fall) begin
        rsp_dr <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_jtag_debug_host_scan_driver.sv
// Directed bench: a shift-register target model on tck for the default
// instance and a tdo-tied-high TCK_HALF=1 instance.
module tb_jtag_debug_host_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [1:0]  cmd_ir, ir_in;
  logic [37:0] cmd_dr, rsp_dr;
  logic        tck, tdi, tdo;
  logic        vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

  logic        cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b, busy_b;
  logic [1:0]  cmd_ir_b, ir_in_b;
  logic [37:0] cmd_dr_b, rsp_dr_b;
  logic        tck_b, tdi_b;
  logic        vs_uir_b, vs_cdr_b, vs_sdr_b, vs_udr_b, rti_b;

  logic [37:0] tgt_tx, tgt_rx, tgt_pre;
  logic        tgt_load;
  int          sdr_rises;
  logic [1:0]  uir_ir;
  time         last_rise_b = 0;
  time         period_b = 0;

  jtag_debug_host_scan_driver #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_HALF(2)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dr(rsp_dr), .busy(busy), .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .jtag_state_rti(jtag_state_rti)
  );

  jtag_debug_host_scan_driver #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_HALF(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_ir(cmd_ir_b), .cmd_dr(cmd_dr_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_dr(rsp_dr_b), .busy(busy_b), .tck(tck_b), .tdi(tdi_b), .tdo(1'b1), .ir_in(ir_in_b),
    .vs_uir(vs_uir_b), .vs_cdr(vs_cdr_b), .vs_sdr(vs_sdr_b), .vs_udr(vs_udr_b),
    .jtag_state_rti(rti_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Target: samples tdi and advances its output register on each shift-DR rise
  always @(posedge tck or posedge tgt_load) begin
    if (tgt_load) begin
      tgt_tx    <= tgt_pre;
      tgt_rx    <= '0;
      sdr_rises <= 0;
      uir_ir    <= '0;
    end else begin
      if (vs_sdr) begin
        tgt_rx    <= {tdi, tgt_rx[37:1]};
        tgt_tx    <= {1'b0, tgt_tx[37:1]};
        sdr_rises <= sdr_rises + 1;
      end
      if (vs_uir) uir_ir <= ir_in;
    end
  end
  assign tdo = tgt_tx[0];

  always @(posedge tck_b) begin
    period_b    <= $time - last_rise_b;
    last_rise_b <= $time;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic loadTarget(input logic [37:0] v);
    tgt_pre  = v;
    tgt_load = 1'b1;
    #1;
    tgt_load = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] ir, input logic [37:0] dr, output int t_acc);
    int n;
    @(negedge clk);
    cmd_ir    = ir;
    cmd_dr    = dr;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_wait", 64'(cmd_ready), 64'd1);
    t_acc = cyc;
  endtask

  task automatic waitResponse(output int t_rsp, output int ready_hits);
    int n;
    n = 0;
    ready_hits = 0;
    while (!rsp_valid && n < 400) begin
      @(negedge clk);
      if (cmd_ready) ready_hits++;
      n++;
    end
    checkOutput("rsp_wait", 64'(rsp_valid), 64'd1);
    t_rsp = cyc;
  endtask

  task automatic consumeResponse();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("consume_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("consume_busy", 64'(busy), 64'd0);
    checkOutput("consume_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    int t_acc, t_rsp, hits, n;
    cmd_valid = 0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 0;
    cmd_valid_b = 0; cmd_ir_b = '0; cmd_dr_b = '0; rsp_ready_b = 0;
    tgt_load = 0; tgt_pre = '0;

    // Reset held for 5 cycles
    repeat (5) @(negedge clk);
    checkOutput("rst_ctrl", 64'({cmd_ready, rsp_valid, busy, tck, tdi}), 64'd0);
    checkOutput("rst_flags", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti}), 64'd0);
    checkOutput("rst_ir_in", 64'(ir_in), 64'd0);
    checkOutput("rst_rsp_dr", 64'(rsp_dr), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("post_rst_tck", 64'(tck), 64'd0);

    // Basic scan with target model
    loadTarget(38'h3F_0000_1234);
    applyStimulus(2'b01, 38'h2A_5555_5555, t_acc);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("scan1_busy", 64'(busy), 64'd1);
    waitResponse(t_rsp, hits);
    checkOutput("scan1_latency", 64'(t_rsp - t_acc), 64'd169);
    checkOutput("scan1_rsp_dr", 64'(rsp_dr), 64'h3F_0000_1234);
    checkOutput("scan1_target_rx", 64'(tgt_rx), 64'h2A_5555_5555);
    checkOutput("scan1_uir_ir", 64'(uir_ir), 64'd1);
    checkOutput("scan1_sdr_rises", 64'(sdr_rises), 64'd38);
    checkOutput("scan1_no_ready", 64'(hits), 64'd0);

    // Response held while rsp_ready stays low
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("hold_rsp_dr", 64'(rsp_dr), 64'h3F_0000_1234);
      checkOutput("hold_tck", 64'(tck), 64'd0);
      checkOutput("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    consumeResponse();
    checkOutput("ir_in_kept", 64'(ir_in), 64'd1);

    // Back-to-back: second command presented with cmd_valid held high
    loadTarget(38'h15_AAAA_0F0F);
    applyStimulus(2'b11, 38'h00_1234_5678, t_acc);
    @(negedge clk);
    cmd_ir = 2'b10;
    cmd_dr = 38'h3C_DEAD_BEEF;
    waitResponse(t_rsp, hits);
    checkOutput("b2b_a_no_ready", 64'(hits), 64'd0);
    checkOutput("b2b_a_latency", 64'(t_rsp - t_acc), 64'd169);
    checkOutput("b2b_a_rsp_dr", 64'(rsp_dr), 64'h15_AAAA_0F0F);
    checkOutput("b2b_a_target_rx", 64'(tgt_rx), 64'h00_1234_5678);
    loadTarget(38'h01_0203_0405);
    consumeResponse();
    t_acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("b2b_b_in_uir", 64'(vs_uir), 64'd1);
    checkOutput("b2b_b_ir_in", 64'(ir_in), 64'd2);
    checkOutput("b2b_b_cmd_ready", 64'(cmd_ready), 64'd0);
    waitResponse(t_rsp, hits);
    checkOutput("b2b_b_latency", 64'(t_rsp - t_acc), 64'd169);
    checkOutput("b2b_b_rsp_dr", 64'(rsp_dr), 64'h01_0203_0405);
    checkOutput("b2b_b_target_rx", 64'(tgt_rx), 64'h3C_DEAD_BEEF);
    checkOutput("b2b_b_uir_ir", 64'(uir_ir), 64'd2);
    consumeResponse();

    // Asynchronous reset in the middle of shift-DR
    loadTarget(38'h2B_CDEF_0123);
    applyStimulus(2'b01, 38'h11_1111_1111, t_acc);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (sdr_rises < 17 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_sdr_bit17", 64'(sdr_rises), 64'd17);
    checkOutput("mid_sdr_tck_high", 64'({vs_sdr, tck}), 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_tck", 64'(tck), 64'd0);
    checkOutput("arst_vs_sdr", 64'(vs_sdr), 64'd0);
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_rsp_dr", 64'(rsp_dr), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) hits++;
    end
    checkOutput("arst_no_response", 64'(hits), 64'd0);

    // TCK_HALF=1 instance, tdo tied high
    @(negedge clk);
    cmd_ir_b    = 2'b10;
    cmd_dr_b    = '0;
    cmd_valid_b = 1'b1;
    n = 0;
    while (!cmd_ready_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fast_accept_wait", 64'(cmd_ready_b), 64'd1);
    t_acc = cyc;
    @(negedge clk);
    cmd_valid_b = 1'b0;
    n = 0;
    while (!rsp_valid_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fast_rsp_wait", 64'(rsp_valid_b), 64'd1);
    checkOutput("fast_latency", 64'(cyc - t_acc), 64'd85);
    checkOutput("fast_rsp_dr", 64'(rsp_dr_b), 64'h3F_FFFF_FFFF);
    checkOutput("fast_tck_period", 64'(period_b), 64'd20);
    checkOutput("fast_ir_in", 64'(ir_in_b), 64'd2);
    rsp_ready_b = 1'b1;
    @(negedge clk);
    rsp_ready_b = 1'b0;
    checkOutput("fast_consumed", 64'({rsp_valid_b, busy_b, cmd_ready_b}), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
